// File: rtl/ldpc_cnu_pipe.sv
// ldpc_cnu_pipe: five-stage min-sum check-node unit for the layered LDPC decoder.
// Stage 1 registers the beat. Stage 2 removes the old check message.
// Stage 3 finds min1/min2/idx/signs. Stage 4 applies the correction.
// Stage 5 adds the new check message back and emits the compressed Lr.
// One global enable stalls every stage while the output is held by the consumer.
module ldpc_cnu_pipe #(
   parameter  int D_WID = 8,
   parameter  int DEG   = 6,
   parameter  int IDX_W = 3,
   localparam int CLR_W = 2*(D_WID-1)+IDX_W+1+DEG
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 first_iter,
   input  logic                 nms_mode,
   input  logic [D_WID-2:0]     offset,
   input  logic [DEG*D_WID-1:0] lq_in,
   input  logic [CLR_W-1:0]     clr_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DEG*D_WID-1:0] lq_out,
   output logic [CLR_W-1:0]     clr_out,
   output logic                 sat_flag
);

   localparam int MAG_W = D_WID-1;
   localparam int LQ_W  = DEG*D_WID;
   // Symmetric clamp limits; the most negative code is never produced.
   localparam logic signed [D_WID:0] POS_LIM = {2'b00, {(D_WID-1){1'b1}}};
   localparam logic signed [D_WID:0] NEG_LIM = -POS_LIM;

   // Returns {clamped_flag, clamped_value}.
   function automatic logic [D_WID:0] sat_clamp(input logic signed [D_WID:0] x);
      logic [D_WID:0] r;
      if (x > POS_LIM)
         r = {1'b1, POS_LIM[D_WID-1:0]};
      else if (x < NEG_LIM)
         r = {1'b1, NEG_LIM[D_WID-1:0]};
      else
         r = {1'b0, x[D_WID-1:0]};
      return r;
   endfunction

   // Signed Lr value of one position of a compressed check message.
   // An idx outside 0..DEG-1 never matches a position, so every lane takes min1.
   function automatic logic signed [D_WID:0] expand_lr(
      input logic [CLR_W-1:0] c,
      input logic [IDX_W-1:0] pos,
      input logic             sgn_i
   );
      logic [MAG_W-1:0]      mag;
      logic signed [D_WID:0] v;
      mag = (c[DEG+1 +: IDX_W] == pos) ? c[CLR_W-MAG_W-1 -: MAG_W] : c[CLR_W-1 -: MAG_W];
      v   = $signed({2'b00, mag});
      return (c[DEG] ^ sgn_i) ? -v : v;
   endfunction

   // Normalised (x0.75) or offset correction of one magnitude.
   function automatic logic [MAG_W-1:0] correct_mag(
      input logic [MAG_W-1:0] m,
      input logic             mode,
      input logic [MAG_W-1:0] off
   );
      logic [MAG_W-1:0] r;
      if (!mode)
         r = (m >> 1) + (m >> 2);
      else if (m > off)
         r = m - off;
      else
         r = '0;
      return r;
   endfunction

   logic en;

   // Stage 1 registers
   logic             v1_q, fi1_q, mode1_q;
   logic [MAG_W-1:0] off1_q;
   logic [LQ_W-1:0]  lq1_q;
   logic [CLR_W-1:0] clr1_q;
   // Stage 2 registers
   logic             v2_q, sat2_q, mode2_q;
   logic [MAG_W-1:0] off2_q;
   logic [LQ_W-1:0]  q2_d, q2_q;
   logic [DEG-1:0]   sat2_lane;
   // Stage 3 registers
   logic             v3_q, sat3_q, mode3_q, sgntot3_d, sgntot3_q;
   logic [MAG_W-1:0] off3_q, min1_3_d, min1_3_q, min2_3_d, min2_3_q;
   logic [IDX_W-1:0] idx3_d, idx3_q;
   logic [DEG-1:0]   sgn3_d, sgn3_q;
   logic [LQ_W-1:0]  q3_q;
   logic [MAG_W-1:0] mag3 [DEG];
   // Stage 4 registers
   logic             v4_q, sat4_q, sgntot4_q;
   logic [MAG_W-1:0] min1_4_q, min2_4_q;
   logic [IDX_W-1:0] idx4_q;
   logic [DEG-1:0]   sgn4_q;
   logic [LQ_W-1:0]  q4_q;
   // Stage 5 (output) registers
   logic             out_valid_q, sat_flag_q;
   logic [LQ_W-1:0]  lq5_d, lq_out_q;
   logic [CLR_W-1:0] clr5_d, clr_out_q;
   logic [DEG-1:0]   sat5_lane;

   // The whole pipe moves unless a valid output is being held back.
   assign en       = ~out_valid_q | out_ready;
   assign in_ready = en;

   // Stage 1: capture the accepted beat and its per-beat controls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1_q    <= 1'b0;
         fi1_q   <= 1'b0;
         mode1_q <= 1'b0;
         off1_q  <= '0;
         lq1_q   <= '0;
         clr1_q  <= '0;
      end else if (en) begin
         v1_q    <= in_valid;
         fi1_q   <= first_iter;
         mode1_q <= nms_mode;
         off1_q  <= offset;
         lq1_q   <= lq_in;
         clr1_q  <= clr_in;
      end
   end

   // Stage 2 lanes: q = lq - old Lr (or lq alone on the first iteration), saturated.
   for (genvar gi = 0; gi < DEG; gi++) begin : g_s2
      logic signed [D_WID:0] ext, diff;
      logic [D_WID:0]        res;
      assign ext  = {lq1_q[(DEG-gi)*D_WID-1], lq1_q[(DEG-1-gi)*D_WID +: D_WID]};
      assign diff = fi1_q ? ext : ext - expand_lr(clr1_q, IDX_W'(gi), clr1_q[DEG-1-gi]);
      assign res  = sat_clamp(diff);
      assign q2_d[(DEG-1-gi)*D_WID +: D_WID] = res[D_WID-1:0];
      assign sat2_lane[gi] = res[D_WID];
   end

   // Stage 2: register the extrinsic values and their clamp flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v2_q    <= 1'b0;
         sat2_q  <= 1'b0;
         mode2_q <= 1'b0;
         off2_q  <= '0;
         q2_q    <= '0;
      end else if (en) begin
         v2_q    <= v1_q;
         sat2_q  <= |sat2_lane;
         mode2_q <= mode1_q;
         off2_q  <= off1_q;
         q2_q    <= q2_d;
      end
   end

   // Stage 3 lanes: magnitude and sign; q is already clamped, so |q| fits MAG_W bits.
   for (genvar gi = 0; gi < DEG; gi++) begin : g_s3
      logic [D_WID-1:0] ql, ab;
      assign ql   = q2_q[(DEG-1-gi)*D_WID +: D_WID];
      assign ab   = ql[D_WID-1] ? (~ql + 1'b1) : ql;
      assign mag3[gi] = ab[MAG_W-1:0];
      assign sgn3_d[DEG-1-gi] = ql[D_WID-1];
   end

   // min1 chain: strict compare keeps the lowest index on ties.
   for (genvar gi = 0; gi < DEG; gi++) begin : g_min1
      logic [MAG_W-1:0] m;
      logic [IDX_W-1:0] id;
      if (gi == 0) begin : g_head
         assign m  = mag3[0];
         assign id = '0;
      end else begin : g_tail
         assign m  = (mag3[gi] < g_min1[gi-1].m) ? mag3[gi] : g_min1[gi-1].m;
         assign id = (mag3[gi] < g_min1[gi-1].m) ? IDX_W'(gi) : g_min1[gi-1].id;
      end
   end

   // min2 chain: smallest magnitude over every position except idx.
   for (genvar gi = 0; gi < DEG; gi++) begin : g_min2
      logic [MAG_W-1:0] m, prev;
      if (gi == 0) begin : g_head
         assign prev = '1;
      end else begin : g_tail
         assign prev = g_min2[gi-1].m;
      end
      assign m = ((IDX_W'(gi) != idx3_d) && (mag3[gi] < prev)) ? mag3[gi] : prev;
   end

   assign min1_3_d  = g_min1[DEG-1].m;
   assign idx3_d    = g_min1[DEG-1].id;
   assign min2_3_d  = g_min2[DEG-1].m;
   assign sgntot3_d = ^sgn3_d;

   // Stage 3: register the raw minima, index and signs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v3_q      <= 1'b0;
         sat3_q    <= 1'b0;
         mode3_q   <= 1'b0;
         off3_q    <= '0;
         q3_q      <= '0;
         min1_3_q  <= '0;
         min2_3_q  <= '0;
         idx3_q    <= '0;
         sgn3_q    <= '0;
         sgntot3_q <= 1'b0;
      end else if (en) begin
         v3_q      <= v2_q;
         sat3_q    <= sat2_q;
         mode3_q   <= mode2_q;
         off3_q    <= off2_q;
         q3_q      <= q2_q;
         min1_3_q  <= min1_3_d;
         min2_3_q  <= min2_3_d;
         idx3_q    <= idx3_d;
         sgn3_q    <= sgn3_d;
         sgntot3_q <= sgntot3_d;
      end
   end

   // Stage 4: correct both minima with the mode carried from stage 1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v4_q      <= 1'b0;
         sat4_q    <= 1'b0;
         q4_q      <= '0;
         min1_4_q  <= '0;
         min2_4_q  <= '0;
         idx4_q    <= '0;
         sgn4_q    <= '0;
         sgntot4_q <= 1'b0;
      end else if (en) begin
         v4_q      <= v3_q;
         sat4_q    <= sat3_q;
         q4_q      <= q3_q;
         min1_4_q  <= correct_mag(min1_3_q, mode3_q, off3_q);
         min2_4_q  <= correct_mag(min2_3_q, mode3_q, off3_q);
         idx4_q    <= idx3_q;
         sgn4_q    <= sgn3_q;
         sgntot4_q <= sgntot3_q;
      end
   end

   assign clr5_d = {min1_4_q, min2_4_q, idx4_q, sgntot4_q, sgn4_q};

   // Stage 5 lanes: new posterior = q + new Lr, saturated.
   for (genvar gi = 0; gi < DEG; gi++) begin : g_s5
      logic signed [D_WID:0] ext, sum;
      logic [D_WID:0]        res;
      assign ext = {q4_q[(DEG-gi)*D_WID-1], q4_q[(DEG-1-gi)*D_WID +: D_WID]};
      assign sum = ext + expand_lr(clr5_d, IDX_W'(gi), sgn4_q[DEG-1-gi]);
      assign res = sat_clamp(sum);
      assign lq5_d[(DEG-1-gi)*D_WID +: D_WID] = res[D_WID-1:0];
      assign sat5_lane[gi] = res[D_WID];
   end

   // Stage 5: output registers, held while the consumer stalls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         lq_out_q    <= '0;
         clr_out_q   <= '0;
         sat_flag_q  <= 1'b0;
      end else if (en) begin
         out_valid_q <= v4_q;
         lq_out_q    <= lq5_d;
         clr_out_q   <= clr5_d;
         sat_flag_q  <= sat4_q | (|sat5_lane);
      end
   end

   assign out_valid = out_valid_q;
   assign lq_out    = lq_out_q;
   assign clr_out   = clr_out_q;
   assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_ldpc_cnu_pipe.sv
// tb_ldpc_cnu_pipe: directed checks of the min-sum check-node pipe with hand-computed vectors.
module tb_ldpc_cnu_pipe;

   localparam int D_WID = 8;
   localparam int DEG   = 6;
   localparam int IDX_W = 3;
   localparam int CLR_W = 2*(D_WID-1)+IDX_W+1+DEG;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 in_valid;
   logic                 in_ready;
   logic                 first_iter;
   logic                 nms_mode;
   logic [D_WID-2:0]     offset;
   logic [DEG*D_WID-1:0] lq_in;
   logic [CLR_W-1:0]     clr_in;
   logic                 out_valid;
   logic                 out_ready;
   logic [DEG*D_WID-1:0] lq_out;
   logic [CLR_W-1:0]     clr_out;
   logic                 sat_flag;

   int n_checks = 0;
   int n_errors = 0;
   int k;
   int n_out;
   int seen;

   ldpc_cnu_pipe #(.D_WID(D_WID), .DEG(DEG), .IDX_W(IDX_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .first_iter (first_iter),
      .nms_mode   (nms_mode),
      .offset     (offset),
      .lq_in      (lq_in),
      .clr_in     (clr_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .lq_out     (lq_out),
      .clr_out    (clr_out),
      .sat_flag   (sat_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Six signed samples, position 0 in the MSBs.
   function automatic logic [47:0] pk6(input int a0, a1, a2, a3, a4, a5);
      return {8'(a0), 8'(a1), 8'(a2), 8'(a3), 8'(a4), 8'(a5)};
   endfunction

   function automatic logic [23:0] pkc(input int m1, m2, idx, st, input logic [5:0] sgn);
      return {7'(m1), 7'(m2), 3'(idx), 1'(st), sgn};
   endfunction

   // Single beat into an idle pipe, then compare latency and results.
   task automatic run_one(input string tag, input logic [47:0] lq, input logic [23:0] clr,
                          input logic fi, input logic md, input logic [6:0] off,
                          input logic [47:0] exp_lq, input logic [23:0] exp_clr, input logic exp_sat);
      int lat;
      @(negedge clk);
      lq_in = lq; clr_in = clr; first_iter = fi; nms_mode = md; offset = off; in_valid = 1'b1;
      #1 check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
      end
      check({tag, "_latency"}, 64'(lat), 64'd5);
      check({tag, "_lq_out"}, 64'(lq_out), 64'(exp_lq));
      check({tag, "_clr_out"}, 64'(clr_out), 64'(exp_clr));
      check({tag, "_sat_flag"}, 64'(sat_flag), 64'(exp_sat));
      $display("txn %s lq_out=%h clr_out=%h sat=%0d lat=%0d", tag, lq_out, clr_out, sat_flag, lat);
      @(negedge clk);
      check({tag, "_single"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; first_iter = 1'b0; nms_mode = 1'b0;
      offset = '0; lq_in = '0; clr_in = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_lq_out", 64'(lq_out), 64'd0);
      check("rst_clr_out", 64'(clr_out), 64'd0);
      check("rst_sat_flag", 64'(sat_flag), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      reset_n = 1'b1;

      run_one("nms", pk6(10,-3,7,20,-5,4), '0, 1'b1, 1'b0, 7'd0,
              pk6(11,-6,8,21,-6,5), pkc(1,3,1,0,6'b010010), 1'b0);
      run_one("oms", pk6(10,-3,7,20,-5,4), '0, 1'b1, 1'b1, 7'd2,
              pk6(11,-5,8,21,-6,5), pkc(1,2,1,0,6'b010010), 1'b0);
      run_one("roundtrip", pk6(11,-6,8,21,-6,5), pkc(1,3,1,0,6'b010010), 1'b0, 1'b0, 7'd0,
              pk6(11,-6,8,21,-6,5), pkc(1,3,1,0,6'b010010), 1'b0);
      run_one("sat_in", pk6(127,-128,50,60,70,80), '0, 1'b1, 1'b0, 7'd0,
              pk6(90,-90,5,23,33,43), pkc(37,45,2,1,6'b010000), 1'b1);
      run_one("idx_oob", pk6(-120,30,30,30,30,30), pkc(20,20,7,0,6'b000000), 1'b0, 1'b0, 7'd0,
              pk6(-120,3,3,3,3,3), pkc(7,7,1,1,6'b100000), 1'b1);
      run_one("tie", pk6(5,5,5,5,5,5), '0, 1'b1, 1'b0, 7'd0,
              pk6(8,8,8,8,8,8), pkc(3,3,0,0,6'b000000), 1'b0);

      // Eight back-to-back beats with the consumer stalling for three cycles.
      k = 0; n_out = 0;
      for (int cyc = 0; cyc < 60 && n_out < 8; cyc++) begin
         @(negedge clk);
         out_ready  = !(cyc >= 6 && cyc <= 8);
         in_valid   = (k < 8);
         lq_in      = pk6(k+1, 20, 20, 20, 20, 20);
         clr_in     = '0;
         first_iter = 1'b1;
         nms_mode   = 1'b0;
         #1;
         if (cyc >= 6 && cyc <= 8) check("bp_stall_in_ready", 64'(in_ready), 64'd0);
         if (in_valid && in_ready) k++;
         if (out_valid && out_ready) begin
            check("bp_order_lane0", 64'(lq_out[47:40]), 64'(n_out+16));
            $display("txn bp beat=%0d lq_out=%h clr_out=%h", n_out, lq_out, clr_out);
            n_out++;
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("bp_count_out", 64'(n_out), 64'd8);
      check("bp_count_in", 64'(k), 64'd8);
      @(negedge clk);
      #1 check("bp_no_dup", 64'(out_valid), 64'd0);

      // Reset with the first beat at the output and two more in flight.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         lq_in = pk6(i+1, 9, 9, 9, 9, 9);
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 check("rst_mid_pre_valid", 64'(out_valid), 64'd1);
      reset_n = 1'b0;
      #1;
      check("rst_mid_out_valid", 64'(out_valid), 64'd0);
      check("rst_mid_lq_out", 64'(lq_out), 64'd0);
      check("rst_mid_clr_out", 64'(clr_out), 64'd0);
      $display("txn reset_mid out_valid=%0d", out_valid);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("rst_mid_no_stale", 64'(seen), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
